// File: rtl/execute_md.sv
// Execute stage: forwarding muxes, single-cycle ALU and an iterative radix-2 multiply/divide unit.
// Define EXECUTE_MD_DIV_EN to include the DIVU/REMU divider; without it those codes return 0.
module execute_md #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 7
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            StallE,
  input  logic            FlushE,
  input  logic [3:0]      ALUControlD,
  input  logic            ALUSrcD,
  input  logic [XLEN-1:0] RD1D,
  input  logic [XLEN-1:0] RD2D,
  input  logic [XLEN-1:0] PCD,
  input  logic [XLEN-1:0] ImmExtD,
  input  logic [XLEN-1:0] PCPlus4D,
  input  logic [4:0]      Rs1D,
  input  logic [4:0]      Rs2D,
  input  logic [4:0]      RdD,
  input  logic [1:0]      ForwardAE,
  input  logic [1:0]      ForwardBE,
  input  logic [XLEN-1:0] ALUResultM,
  input  logic [XLEN-1:0] ResultW,
  output logic [XLEN-1:0] ALUResultE,
  output logic            ZeroE,
  output logic [XLEN-1:0] PCTargetE,
  output logic [XLEN-1:0] WriteDataE,
  output logic [XLEN-1:0] PCPlus4E,
  output logic [4:0]      RdE,
  output logic [4:0]      Rs1E,
  output logic [4:0]      Rs2E,
  output logic            BusyE
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  logic [3:0]      alu_control_p0;
  logic            alu_src_p0;
  logic [XLEN-1:0] rd1_p0, rd2_p0, pc_p0, imm_ext_p0;

  logic [XLEN-1:0] src_a, src_b, alu_result, md_result;
  logic signed [XLEN-1:0] src_a_s, src_b_s;

  state_t          state;
  logic [CNT_W-1:0] cnt;
  logic [XLEN-1:0] acc_hi, acc_lo, operand;
  logic            md_hi;
  logic            md_start;
  logic [XLEN:0]   mul_sum;

  function automatic logic is_md_op(input logic [3:0] op);
`ifdef EXECUTE_MD_DIV_EN
    return op[3:2] == 2'b10;
`else
    return op[3:1] == 3'b100;
`endif
  endfunction

  // ---- D -> E register boundary
  always_ff @(posedge clock) begin
    if (reset || FlushE) begin
      alu_control_p0 <= '0;
      alu_src_p0     <= 1'b0;
      rd1_p0         <= '0;
      rd2_p0         <= '0;
      pc_p0          <= '0;
      imm_ext_p0     <= '0;
      PCPlus4E       <= '0;
      RdE            <= '0;
      Rs1E           <= '0;
      Rs2E           <= '0;
    end else if (!StallE) begin
      alu_control_p0 <= ALUControlD;
      alu_src_p0     <= ALUSrcD;
      rd1_p0         <= RD1D;
      rd2_p0         <= RD2D;
      pc_p0          <= PCD;
      imm_ext_p0     <= ImmExtD;
      PCPlus4E       <= PCPlus4D;
      RdE            <= RdD;
      Rs1E           <= Rs1D;
      Rs2E           <= Rs2D;
    end
  end

  always_comb begin
    case (ForwardAE)
      2'b01:   src_a = ResultW;
      2'b10:   src_a = ALUResultM;
      default: src_a = rd1_p0;
    endcase
    case (ForwardBE)
      2'b01:   WriteDataE = ResultW;
      2'b10:   WriteDataE = ALUResultM;
      default: WriteDataE = rd2_p0;
    endcase
  end

  assign src_b     = alu_src_p0 ? imm_ext_p0 : WriteDataE;
  assign src_a_s   = src_a;
  assign src_b_s   = src_b;
  assign PCTargetE = pc_p0 + imm_ext_p0;

  always_comb begin
    case (alu_control_p0)
      4'b0000: alu_result = src_a + src_b;
      4'b0001: alu_result = src_a - src_b;
      4'b0010: alu_result = src_a & src_b;
      4'b0011: alu_result = src_a | src_b;
      4'b0100: alu_result = src_a ^ src_b;
      4'b0101: alu_result = {{(XLEN-1){1'b0}}, src_a_s < src_b_s};
      4'b0110: alu_result = {{(XLEN-1){1'b0}}, src_a < src_b};
      default: alu_result = '0;
    endcase
  end

  // Multiply keeps {acc_hi, acc_lo} as partial product / remaining multiplier bits;
  // divide keeps remainder in acc_hi and shifts quotient bits into acc_lo.
  assign mul_sum = {1'b0, acc_hi} + {1'b0, (acc_lo[0] ? operand : {XLEN{1'b0}})};

`ifdef EXECUTE_MD_DIV_EN
  logic            md_div;
  logic [XLEN:0]   div_shift;
  logic            div_ge;
  logic [XLEN-1:0] div_rem;

  assign div_shift = {acc_hi, acc_lo[XLEN-1]};
  assign div_ge    = div_shift >= {1'b0, operand};
  assign div_rem   = div_shift[XLEN-1:0] - operand;
`endif

  assign md_start = (state == IDLE) && is_md_op(alu_control_p0);
  assign BusyE    = md_start || (state == RUN);

  // ---- multiply/divide iteration state
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      acc_hi  <= '0;
      acc_lo  <= '0;
      operand <= '0;
      md_hi   <= 1'b0;
`ifdef EXECUTE_MD_DIV_EN
      md_div  <= 1'b0;
`endif
    end else if (FlushE) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (md_start) begin
            state  <= RUN;
            cnt    <= CNT_W'(XLEN);
            md_hi  <= alu_control_p0[0];
            acc_hi <= '0;
`ifdef EXECUTE_MD_DIV_EN
            md_div  <= alu_control_p0[1];
            acc_lo  <= alu_control_p0[1] ? src_a : src_b;
            operand <= alu_control_p0[1] ? src_b : src_a;
`else
            acc_lo  <= src_b;
            operand <= src_a;
`endif
          end
        end
        RUN: begin
          cnt <= cnt - CNT_W'(1);
`ifdef EXECUTE_MD_DIV_EN
          if (md_div) begin
            acc_hi <= div_ge ? div_rem : div_shift[XLEN-1:0];
            acc_lo <= {acc_lo[XLEN-2:0], div_ge};
          end else begin
            {acc_hi, acc_lo} <= {mul_sum, acc_lo[XLEN-1:1]};
          end
`else
          {acc_hi, acc_lo} <= {mul_sum, acc_lo[XLEN-1:1]};
`endif
          if (cnt == CNT_W'(1)) state <= DONE;
        end
        DONE: begin
          if (!StallE) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign md_result = md_hi ? acc_hi : acc_lo;

  always_comb begin
    if (state == DONE)          ALUResultE = md_result;
    else if (alu_control_p0[3]) ALUResultE = '0;
    else                        ALUResultE = alu_result;
  end

  assign ZeroE = (ALUResultE == '0);

endmodule

// File: tb/tb_execute_md.sv
// Scoreboard bench for execute_md (XLEN=64): stimulus pushes expected results, a monitor pops and compares.
module tb_execute_md;

  logic        clock, reset, StallE, FlushE, ALUSrcD;
  logic [3:0]  ALUControlD;
  logic [63:0] RD1D, RD2D, PCD, ImmExtD, PCPlus4D, ALUResultM, ResultW;
  logic [4:0]  Rs1D, Rs2D, RdD;
  logic [1:0]  ForwardAE, ForwardBE;
  logic [63:0] ALUResultE, PCTargetE, WriteDataE, PCPlus4E;
  logic        ZeroE, BusyE;
  logic [4:0]  RdE, Rs1E, Rs2E;
  logic        tb_stall, rst_q;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [63:0] res;
    logic        zero;
    int          busy;
    logic [63:0] pct;
    logic [4:0]  rd;
    logic [63:0] wd;
    bit          chk_wd;
  } exp_t;

  exp_t q[$];

  execute_md #(.XLEN(64), .CNT_W(7)) dut (
    .clock(clock), .reset(reset), .StallE(StallE), .FlushE(FlushE),
    .ALUControlD(ALUControlD), .ALUSrcD(ALUSrcD),
    .RD1D(RD1D), .RD2D(RD2D), .PCD(PCD), .ImmExtD(ImmExtD), .PCPlus4D(PCPlus4D),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .ALUResultM(ALUResultM), .ResultW(ResultW),
    .ALUResultE(ALUResultE), .ZeroE(ZeroE), .PCTargetE(PCTargetE),
    .WriteDataE(WriteDataE), .PCPlus4E(PCPlus4E),
    .RdE(RdE), .Rs1E(Rs1E), .Rs2E(Rs2E), .BusyE(BusyE)
  );

  // The hazard unit stalls E whenever the MD unit is busy.
  assign StallE = BusyE | tb_stall;

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) rst_q <= reset;

  function automatic logic [63:0] model_res(input logic [3:0] op, input logic [63:0] x, input logic [63:0] y);
    logic [127:0] p;
    p = {64'd0, x} * {64'd0, y};
    case (op)
      4'd0: return x + y;
      4'd1: return x - y;
      4'd2: return x & y;
      4'd3: return x | y;
      4'd4: return x ^ y;
      4'd5: return ($signed(x) < $signed(y)) ? 64'd1 : 64'd0;
      4'd6: return (x < y) ? 64'd1 : 64'd0;
      4'd8: return p[63:0];
      4'd9: return p[127:64];
`ifdef EXECUTE_MD_DIV_EN
      4'd10: return (y == 64'd0) ? {64{1'b1}} : x / y;
      4'd11: return (y == 64'd0) ? x : x % y;
`endif
      default: return 64'd0;
    endcase
  endfunction

  function automatic int model_busy(input logic [3:0] op);
    if (op == 4'd8 || op == 4'd9) return 65;
`ifdef EXECUTE_MD_DIV_EN
    if (op == 4'd10 || op == 4'd11) return 65;
`endif
    return 0;
  endfunction

  function automatic logic [63:0] pick();
    case ($urandom_range(0, 5))
      0: return 64'd0;
      1: return {64{1'b1}};
      2: return 64'h8000_0000_0000_0000;
      3: return 64'($urandom_range(0, 20));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  // Monitor: compares whenever an issued instruction presents a non-busy result.
  initial begin : monitor
    int   busy_cnt;
    exp_t e;
    busy_cnt = 0;
    forever begin
      @(negedge clock);
      if (rst_q === 1'b1) begin
        chk("rst_alu",  ALUResultE, 64'd0);
        chk("rst_zero", 64'(ZeroE), 64'd1);
        chk("rst_busy", 64'(BusyE), 64'd0);
        chk("rst_pct",  PCTargetE, 64'd0);
        chk("rst_wd",   WriteDataE, 64'd0);
        chk("rst_rd",   64'(RdE), 64'd0);
      end else if (q.size() > 0) begin
        if (BusyE === 1'b1) begin
          busy_cnt++;
        end else begin
          e = q[0];
          chk("result", ALUResultE, e.res);
          chk("zero",   64'(ZeroE), 64'(e.zero));
          chk("busy_cycles", 64'(busy_cnt), 64'(e.busy));
          chk("pctarget", PCTargetE, e.pct);
          chk("rd", 64'(RdE), 64'(e.rd));
          if (e.chk_wd) chk("writedata", WriteDataE, e.wd);
          if (StallE === 1'b0) begin
            void'(q.pop_front());
            busy_cnt = 0;
          end
        end
      end
    end
  end

  task automatic bubble_d();
    ALUControlD = 4'd0; ALUSrcD = 1'b0;
    RD1D = 64'd0; RD2D = 64'd0; PCD = 64'd0; ImmExtD = 64'd0; PCPlus4D = 64'd0;
    Rs1D = 5'd0; Rs2D = 5'd0; RdD = 5'd0;
  endtask

  task automatic quiet_fwd();
    ForwardAE = 2'd0; ForwardBE = 2'd0; ALUResultM = 64'd0; ResultW = 64'd0;
  endtask

  // mode: 0 normal, 1 hold DONE with 3 stall cycles, 2 flush at RUN cycle 10, 3 reset at RUN cycle 5
  task automatic issue(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] imm, input logic src, input logic [1:0] fa,
                       input logic [1:0] fb, input logic [63:0] m, input logic [63:0] w,
                       input int mode);
    logic [63:0] sa, sbr, sb, pc;
    logic [4:0]  rd;
    exp_t        e;
    int          n, hold_n;
    bit          held;
    pc = {$urandom, $urandom};
    rd = 5'($urandom_range(1, 31));
    ALUControlD = op; ALUSrcD = src; RD1D = a; RD2D = b; ImmExtD = imm;
    PCD = pc; PCPlus4D = pc + 64'd4; RdD = rd; Rs1D = rd ^ 5'd1; Rs2D = rd ^ 5'd2;
    sa  = (fa == 2'd1) ? w : (fa == 2'd2) ? m : a;
    sbr = (fb == 2'd1) ? w : (fb == 2'd2) ? m : b;
    sb  = src ? imm : sbr;
    if (mode >= 2) begin
      e.res = 64'd0; e.zero = 1'b1; e.busy = (mode == 2) ? 11 : 6;
      e.pct = 64'd0; e.rd = 5'd0; e.wd = 64'd0; e.chk_wd = 1'b1;
    end else begin
      e.res = model_res(op, sa, sb); e.zero = (e.res == 64'd0); e.busy = model_busy(op);
      e.pct = pc + imm; e.rd = rd; e.wd = sbr; e.chk_wd = (op[3] == 1'b0);
    end
    @(posedge clock); #1;
    ForwardAE = fa; ForwardBE = fb; ALUResultM = m; ResultW = w;
    q.push_back(e);
    bubble_d();
    n = 0; held = 1'b0; hold_n = 0;
    while (q.size() > 0) begin
      @(posedge clock); #1;
      n++;
      if (n > 300) begin
        $display("FAIL timeout op %0d waited %0d cycles want at most 300", op, n);
        $fatal(1, "timeout");
      end
      if (BusyE === 1'b1) begin
        ForwardAE  = 2'($urandom_range(0, 2));
        ForwardBE  = 2'($urandom_range(0, 2));
        ALUResultM = (n == 1) ? 64'd1 : {$urandom, $urandom};
        ResultW    = {$urandom, $urandom};
      end
      if (mode == 1) begin
        if (held && n == hold_n + 3) tb_stall = 1'b0;
        if (!held && BusyE === 1'b0) begin
          tb_stall = 1'b1; held = 1'b1; hold_n = n;
        end
      end
      if (mode == 2 && n == 10) begin FlushE = 1'b1; quiet_fwd(); end
      if (mode == 2 && n == 11) FlushE = 1'b0;
      if (mode == 3 && n == 5) begin reset = 1'b1; quiet_fwd(); end
      if (mode == 3 && n == 6) reset = 1'b0;
    end
  endtask

  initial begin : stimulus
    reset = 1'b1; FlushE = 1'b0; tb_stall = 1'b0;
    bubble_d(); quiet_fwd();
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;

    issue(4'd0, 64'd5, -64'd3, 64'd16, 1'b0, 2'd0, 2'd0, 64'd0, 64'd0, 0);
    issue(4'd8, 64'd7, 64'd6, 64'd4, 1'b0, 2'd0, 2'd0, 64'd0, 64'd0, 0);
    issue(4'd9, 64'h8000_0000_0000_0000, 64'd4, 64'd8, 1'b0, 2'd0, 2'd0, 64'd0, 64'd0, 0);
    issue(4'd10, 64'd100, 64'd7, 64'd0, 1'b0, 2'd0, 2'd0, 64'd0, 64'd0, 0);
    issue(4'd11, 64'd100, 64'd7, 64'd0, 1'b0, 2'd0, 2'd0, 64'd0, 64'd0, 0);
    issue(4'd10, 64'd9, 64'd0, 64'd0, 1'b0, 2'd0, 2'd0, 64'd0, 64'd0, 0);
    issue(4'd11, 64'd9, 64'd0, 64'd0, 1'b0, 2'd0, 2'd0, 64'd0, 64'd0, 0);
    issue(4'd12, 64'd9, 64'd3, 64'd0, 1'b0, 2'd0, 2'd0, 64'd0, 64'd0, 0);
    issue(4'd8, 64'd5, 64'd9, 64'd0, 1'b0, 2'd0, 2'd0, 64'd0, 64'd0, 2);
    issue(4'd0, 64'd11, 64'd22, 64'd0, 1'b0, 2'd0, 2'd0, 64'd0, 64'd0, 0);
    issue(4'd8, 64'd55, 64'd3, 64'd0, 1'b0, 2'd2, 2'd0, 64'd8, 64'd77, 0);
    issue(4'd8, 64'd12, 64'd13, 64'd0, 1'b0, 2'd0, 2'd0, 64'd0, 64'd0, 1);
    issue(4'd9, 64'd5, 64'd9, 64'd0, 1'b0, 2'd0, 2'd0, 64'd0, 64'd0, 3);
    issue(4'd1, 64'd4, 64'd4, 64'd0, 1'b0, 2'd0, 2'd0, 64'd0, 64'd0, 0);
    issue(4'd5, -64'd2, 64'd1, 64'd0, 1'b0, 2'd0, 2'd0, 64'd0, 64'd0, 0);
    issue(4'd6, -64'd2, 64'd1, 64'd0, 1'b0, 2'd0, 2'd0, 64'd0, 64'd0, 0);

    for (int i = 0; i < 40; i++) begin
      issue(4'($urandom_range(0, 15)), pick(), pick(), pick(), 1'($urandom_range(0, 1)),
            2'($urandom_range(0, 2)), 2'($urandom_range(0, 2)), pick(), pick(), 0);
    end

    repeat (3) @(posedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/execute_md.md
EXECUTE_MD -- requirements
Module: execute_md

Interface
REQ-001 Parameter XLEN, default 64: datapath width in bits; legal values 32 or 64.
REQ-002 Parameter CNT_W, default 7: iteration-counter width; SHALL satisfy 2^CNT_W > XLEN.
REQ-003 clock  in  1: sole clock; all state updates on its rising edge.
REQ-004 reset  in  1: synchronous, active-high reset.
REQ-005 StallE  in  1: hold the E pipeline register.
REQ-006 FlushE  in  1: clear the E pipeline register and abort any multiply/divide in flight.
REQ-007 ALUControlD  in  4: operation code; [3]=0 is a single-cycle ALU op, [3]=1 is a multiply/divide op.
REQ-008 ALUSrcD  in  1: 1 selects ImmExtE as ALU operand B.
REQ-009 RD1D, RD2D, PCD, ImmExtD, PCPlus4D  in  XLEN each: decode-stage data.
REQ-010 Rs1D, Rs2D, RdD  in  5 each: decode-stage register indices.
REQ-011 ForwardAE, ForwardBE  in  2 each: 00 register value, 01 ResultW, 10 ALUResultM.
REQ-012 ALUResultM, ResultW  in  XLEN each: forwarded results.
REQ-013 ALUResultE  out  XLEN: stage result.
REQ-014 ZeroE  out  1: high when ALUResultE is zero.
REQ-015 PCTargetE  out  XLEN: PCE + ImmExtE, modulo 2^XLEN.
REQ-016 WriteDataE, PCPlus4E  out  XLEN each; RdE, Rs1E, Rs2E  out  5 each.
REQ-017 BusyE  out  1: multiply/divide unit requests a stall of the E stage and all earlier stages.

Function
REQ-018 E register: update when StallE=0; hold when StallE=1; zero all fields when FlushE=1 (FlushE has priority over StallE).
REQ-019 SrcA and WriteDataE: 3:1 forwarding muxes. SrcB: WriteDataE, or ImmExtE when ALUSrcE=1.
REQ-020 ALU ops (combinational, zero latency): 0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor, 0101 signed slt, 0110 unsigned sltu; other [3]=0 codes give 0.
REQ-021 MD ops (unsigned, iterative radix-2): 1000 MUL (low XLEN of product), 1001 MULHU (high XLEN), 1010 DIVU, 1011 REMU; codes 11xx give 0 with no busy cycles.
REQ-022 FSM states: IDLE, RUN, DONE.
REQ-023 IDLE: when an MD op is in E, capture forwarded SrcA/SrcB, load the counter with XLEN, assert BusyE, and go to RUN.
REQ-024 RUN: perform one iteration per cycle with BusyE=1; at the last iteration (counter=1) go to DONE.
REQ-025 DONE: BusyE=0 and ALUResultE = MD result; return to IDLE when StallE=0, otherwise stay in DONE.
REQ-026 MD latency: BusyE high for exactly XLEN+1 cycles; the result is visible in the following cycle.
REQ-027 Divide by zero: DIVU returns all-ones; REMU returns the dividend. Both still take the full latency.
REQ-028 FlushE in RUN or DONE: state goes to IDLE and the counter to 0 on the next edge; BusyE drops in that next cycle.
REQ-029 Captured operands are immune to forwarding and register-value changes during RUN.
REQ-030 BusyE is never asserted for a non-MD op or a bubble.

Reset
REQ-031 On reset: all E-register fields 0, FSM IDLE, counter 0, and MD operand/accumulator registers 0.
REQ-032 During and after reset: ALUResultE=0, ZeroE=1, BusyE=0, PCTargetE=0, all other outputs 0.
REQ-033 Reset during RUN aborts the operation, with no partial result ever presented.

Configuration
REQ-034 Macro EXECUTE_MD_DIV_EN defined: DIVU/REMU are implemented per REQ-021 and REQ-027.
REQ-035 Macro EXECUTE_MD_DIV_EN undefined: the divider logic is absent; 1010/1011 behave like 11xx (result 0, BusyE never set); MUL/MULHU are unchanged.

Verification (XLEN=64)
REQ-036 Add 5+(-3) via RD1/RD2, ForwardAE/BE=00 -> ALUResultE=2 same cycle, BusyE=0, ZeroE=0.
REQ-037 MUL 7*6 -> BusyE high 65 cycles, then ALUResultE=42 in DONE. MULHU 2^63*4 -> 2.
REQ-038 DIVU 100/7 -> 14; REMU 100/7 -> 2; DIVU 9/0 -> 0xFFFF_FFFF_FFFF_FFFF; REMU 9/0 -> 9.
REQ-039 FlushE pulse at RUN cycle 10 of a MUL -> IDLE and BusyE=0 next cycle, E fields 0; a following ADD completes normally.
REQ-040 ForwardAE=10 with ALUResultM=8, MUL by 3, then ALUResultM changed to 1 during RUN -> result 24.
REQ-041 StallE=1 held for 3 cycles in DONE -> result stable for all 4 cycles, then IDLE.
